// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM encoding, datapath width.
package exec_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_BUSY = 2'b01
  } ex_state_e;

endpackage

// File: rtl/execute_stage_iter_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low XLEN bits of the product.
module iter_multiplier
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand_in,
  input  logic [XLEN-1:0] multiplier_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  partial;

  always_comb begin
    partial  = mplier_q[count_q] ? (mcand_q << count_q) : '0;
    // product includes the current iteration so the final cycle can be captured directly
    product  = acc_q + partial;
    done     = busy_q && (count_q == LAST);
    busy     = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = multiplicand_in;
      mplier_d = multiplier_in;
      acc_d    = '0;
      count_d  = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d   = product;
      count_d = count_q + CNT_W'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops registered into EX/WB, MUL via iterative multiplier with stall.
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            register_write_en_in,
  input  logic [2:0]      alu_op_in,
  input  logic [XLEN-1:0] alu_operand1_in,
  input  logic [XLEN-1:0] alu_operand2_in,
  input  logic [4:0]      register_write_addr_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic            register_write_en_out,
  output logic [4:0]      register_write_addr_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic            zero_flag_out
);

  ex_state_e       state_q, state_d;
  logic            valid_q, valid_d;
  logic            wen_q, wen_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [4:0]      hold_addr_q, hold_addr_d;
  logic            hold_en_q, hold_en_d;

  logic [XLEN-1:0] alu_res;
  logic            mul_start, mul_busy, mul_done, stall_raw;
  logic [XLEN-1:0] mul_product;

  always_comb begin
    alu_res = '0;
    case (alu_op_in)
      ALU_ADD: alu_res = alu_operand1_in + alu_operand2_in;
      ALU_SUB: alu_res = alu_operand1_in - alu_operand2_in;
      ALU_AND: alu_res = alu_operand1_in & alu_operand2_in;
      ALU_OR:  alu_res = alu_operand1_in | alu_operand2_in;
      ALU_XOR: alu_res = alu_operand1_in ^ alu_operand2_in;
      ALU_SLL: alu_res = alu_operand1_in << alu_operand2_in[SHAMT_W-1:0];
      ALU_SRL: alu_res = alu_operand1_in >> alu_operand2_in[SHAMT_W-1:0];
      default: alu_res = '0;
    endcase
  end

  assign mul_start = (state_q == ST_IDLE) && valid_in && (alu_op_in == ALU_MUL);

  iter_multiplier #(.XLEN(XLEN)) u_mul (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (mul_start),
    .multiplicand_in (alu_operand1_in),
    .multiplier_in   (alu_operand2_in),
    .busy            (mul_busy),
    .done            (mul_done),
    .product         (mul_product)
  );

  always_comb begin
    state_d     = state_q;
    valid_d     = 1'b0;
    wen_d       = 1'b0;
    addr_d      = addr_q;
    result_d    = result_q;
    zero_d      = zero_q;
    hold_addr_d = hold_addr_q;
    hold_en_d   = hold_en_q;
    stall_raw   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (alu_op_in == ALU_MUL) begin
            stall_raw   = 1'b1;
            state_d     = ST_MUL_BUSY;
            hold_addr_d = register_write_addr_in;
            hold_en_d   = register_write_en_in;
          end else begin
            valid_d  = 1'b1;
            wen_d    = register_write_en_in && (register_write_addr_in != 5'd0);
            addr_d   = register_write_addr_in;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      ST_MUL_BUSY: begin
        // stall drops in the last iteration so upstream advances exactly as the product lands
        stall_raw = !mul_done;
        if (mul_done) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          wen_d    = hold_en_q && (hold_addr_q != 5'd0);
          addr_d   = hold_addr_q;
          result_d = mul_product;
          zero_d   = (mul_product == '0);
        end else if (!mul_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      hold_addr_q <= '0;
      hold_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      hold_addr_q <= hold_addr_d;
      hold_en_q   <= hold_en_d;
    end
  end

  // stall is forced low while reset is held, even if a MUL is presented
  assign stall_out               = rst_n && stall_raw;
  assign valid_out               = valid_q;
  assign register_write_en_out   = wen_q;
  assign register_write_addr_out = addr_q;
  assign alu_result_out          = result_q;
  assign zero_flag_out           = zero_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage: ALU ops, MUL stall timing, x0 suppression, reset mid-MUL.
module tb_execute_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        register_write_en_in;
  logic [2:0]  alu_op_in;
  logic [31:0] alu_operand1_in;
  logic [31:0] alu_operand2_in;
  logic [4:0]  register_write_addr_in;
  logic        stall_out;
  logic        valid_out;
  logic        register_write_en_out;
  logic [4:0]  register_write_addr_out;
  logic [31:0] alu_result_out;
  logic        zero_flag_out;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .valid_in                (valid_in),
    .register_write_en_in    (register_write_en_in),
    .alu_op_in               (alu_op_in),
    .alu_operand1_in         (alu_operand1_in),
    .alu_operand2_in         (alu_operand2_in),
    .register_write_addr_in  (register_write_addr_in),
    .stall_out               (stall_out),
    .valid_out               (valid_out),
    .register_write_en_out   (register_write_en_out),
    .register_write_addr_out (register_write_addr_out),
    .alu_result_out          (alu_result_out),
    .zero_flag_out           (zero_flag_out)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  addr;
    logic        en;
    logic        zero;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // advance one clock, sample 1 unit after the edge, score any due result
  task automatic tick();
    logic exp_v;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    chk("valid_out", valid_out, exp_v);
    if (exp_v) begin
      e = q.pop_front();
      chk("alu_result_out", alu_result_out, e.res);
      chk("write_addr_out", register_write_addr_out, e.addr);
      chk("write_en_out", register_write_en_out, e.en);
      chk("zero_flag_out", zero_flag_out, e.zero);
    end
  endtask

  // present one instruction, hold it while stalled, expect its result the cycle after stall drops
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic en, input logic [31:0] exp_res,
                       input int exp_stalls);
    int   stalls;
    exp_t e;
    stalls                 = 0;
    valid_in               = 1'b1;
    alu_op_in              = op;
    alu_operand1_in        = a;
    alu_operand2_in        = b;
    register_write_addr_in = rd;
    register_write_en_in   = en;
    #1;
    while (stall_out && stalls < 100) begin
      stalls++;
      tick();
      #1;
    end
    chk("stall_cycles", stalls, exp_stalls);
    e.res  = exp_res;
    e.addr = rd;
    e.en   = en && (rd != 5'd0);
    e.zero = (exp_res == 32'd0);
    e.due  = cyc + 1;
    q.push_back(e);
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    rst_n                  = 1'b0;
    valid_in               = 1'b0;
    register_write_en_in   = 1'b0;
    alu_op_in              = ALU_ADD;
    alu_operand1_in        = '0;
    alu_operand2_in        = '0;
    register_write_addr_in = '0;
    #1;
    chk("rst_stall", stall_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_wen", register_write_en_out, 0);
    chk("rst_addr", register_write_addr_out, 0);
    chk("rst_result", alu_result_out, 0);
    chk("rst_zero", zero_flag_out, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    issue(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 32'd12, 0);
    tick();

    issue(ALU_SUB, 32'd3, 32'd5, 5'd4, 1'b1, 32'hFFFF_FFFE, 0);
    issue(ALU_XOR, 32'hFFFF_0000, 32'h0000_FFFF, 5'd5, 1'b1, 32'hFFFF_FFFF, 0);
    issue(ALU_SLL, 32'h1, 32'h23, 5'd6, 1'b1, 32'h0000_0008, 0);
    issue(ALU_SRL, 32'h8000_0000, 32'd31, 5'd7, 1'b0, 32'h0000_0001, 0);
    issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8, 1'b1, 32'hF000_F000, 0);
    issue(ALU_OR,  32'h0000_00F0, 32'h0000_000F, 5'd9, 1'b1, 32'h0000_00FF, 0);

    // MUL in cycle T, result at T+33, the held ADD behind it at T+34
    issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h0000_0001, 32);
    issue(ALU_ADD, 32'd100, 32'd23, 5'd11, 1'b1, 32'd123, 0);

    issue(ALU_SUB, 32'd4, 32'd4, 5'd0, 1'b1, 32'd0, 0);

    // leave a nonzero result on the outputs, then abandon a MUL at count 10 with reset
    issue(ALU_ADD, 32'h50, 32'h5, 5'd7, 1'b1, 32'h55, 0);
    valid_in               = 1'b1;
    alu_op_in              = ALU_MUL;
    alu_operand1_in        = 32'h1234;
    alu_operand2_in        = 32'h10;
    register_write_addr_in = 5'd12;
    register_write_en_in   = 1'b1;
    #1;
    chk("mul_stall_same_cycle", stall_out, 1);
    repeat (11) tick();
    chk("mul_stall_mid", stall_out, 1);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("abort_stall", stall_out, 0);
    chk("abort_valid", valid_out, 0);
    chk("abort_wen", register_write_en_out, 0);
    chk("abort_addr", register_write_addr_out, 0);
    chk("abort_result", alu_result_out, 0);
    chk("abort_zero", zero_flag_out, 0);
    tick();
    rst_n = 1'b1;
    tick();

    issue(ALU_MUL, 32'h1234, 32'h10, 5'd12, 1'b1, 32'h0001_2340, 32);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    chk("scoreboard_drained", q.size(), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
